// File: rtl/mem_bridge_pkg.sv
// Shared types and sizing helpers for the CPU-to-SDRAM memory bridge.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RSP  = 2'd2,
    ACK  = 2'd3
  } state_t;

  localparam int DEF_TO_CYC = 255;

  function automatic int cnt_width(input int to_cyc);
    return $clog2(to_cyc + 1);
  endfunction

  localparam int CNT_W = $clog2(DEF_TO_CYC + 1);

endpackage

// File: rtl/mem_bridge_to_counter.sv
// Saturating cycle counter with clear/enable; hit stays high from TO_CYC-1 until cleared.
module to_counter
  import mem_bridge_pkg::*;
#(
  parameter int TO_CYC = DEF_TO_CYC,
  parameter int W      = cnt_width(TO_CYC)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [W-1:0] SAT = W'(TO_CYC);
  localparam logic [W-1:0] LIM = W'(TO_CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (en && cnt != SAT)  cnt <= cnt + W'(1);
  end

  // Greater-or-equal so a read accepted on the limit cycle still times out in RSP.
  assign hit = (cnt >= LIM);

endmodule

// File: rtl/mem_bridge.sv
// Turns single-cycle CPU load/store pulses into a valid/ready memory command plus
// response, with a busy stall, one-cycle ack and a response timeout.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int              bW       = 16,
  parameter int              aW       = 13,
  parameter int              MAW      = 25,
  parameter logic [MAW-1:0]  BASE     = '0,
  parameter int              TO_CYC   = 255,
  parameter logic [bW-1:0]   ERR_DATA = 16'hDEAD
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cpu_req,
  input  logic           cpu_we,
  input  logic [aW-1:0]  cpu_addr,
  input  logic [bW-1:0]  cpu_wdata,
  output logic           cpu_busy,
  output logic           cpu_ack,
  output logic           cpu_err,
  output logic [bW-1:0]  cpu_rdata,
  output logic           mem_cmd_valid,
  input  logic           mem_cmd_ready,
  output logic           mem_cmd_we,
  output logic [MAW-1:0] mem_cmd_addr,
  output logic [bW-1:0]  mem_cmd_wdata,
  input  logic           mem_rsp_valid,
  input  logic [bW-1:0]  mem_rsp_data,
  output state_t         dbg_state,
  output logic           dbg_stale
);

  state_t           state_q, state_d;
  logic             stale_q, err_q, we_q;
  logic [MAW-1:0]   addr_q;
  logic [bW-1:0]    wdata_q, rdata_q;
  logic             hit, accept, hs, rsp_done, active, to_evt;

  // Command handshake: a transfer happens in a cycle where mem_cmd_valid and
  // mem_cmd_ready are both high; until then we/addr/wdata do not change. Valid may
  // only drop without a transfer when the access times out.
  assign accept   = (state_q == IDLE) && cpu_req && !stale_q;
  assign hs       = (state_q == CMD) && mem_cmd_ready;
  assign rsp_done = (state_q == RSP) && mem_rsp_valid;
  assign active   = (state_q == CMD) || (state_q == RSP);
  assign to_evt   = active && hit && !(hs || rsp_done);

  to_counter #(.TO_CYC(TO_CYC), .W(cnt_width(TO_CYC))) u_to (
    .clk (clk),
    .rst (rst),
    .clr (accept || to_evt),
    .en  (active || stale_q),
    .hit (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CMD;
      CMD: begin
        if (hs)       state_d = we_q ? ACK : RSP;
        else if (hit) state_d = ACK;
      end
      RSP:     if (mem_rsp_valid || hit) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= cpu_we;
        addr_q  <= BASE + {{(MAW-aW){1'b0}}, cpu_addr};
        wdata_q <= cpu_wdata;
      end
      err_q <= to_evt;
      if (rsp_done)               rdata_q <= mem_rsp_data;
      else if (to_evt && !we_q)   rdata_q <= ERR_DATA;
      // A response owed to an abandoned read is swallowed, or forgotten after TO_CYC cycles.
      if (to_evt && state_q == RSP)                stale_q <= 1'b1;
      else if (stale_q && (mem_rsp_valid || hit))  stale_q <= 1'b0;
    end
  end

  assign cpu_busy      = (state_q != IDLE);
  assign cpu_ack       = (state_q == ACK);
  assign cpu_err       = err_q;
  assign cpu_rdata     = rdata_q;
  assign mem_cmd_valid = (state_q == CMD);
  assign mem_cmd_we    = we_q;
  assign mem_cmd_addr  = addr_q;
  assign mem_cmd_wdata = wdata_q;
  assign dbg_state     = state_q;
  assign dbg_stale     = stale_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: per-cycle vector table plus hand-written timeout,
// stale and reset sequences. A second instance with a high BASE checks address wrap.
module tb_mem_bridge;
  import mem_bridge_pkg::*;

  localparam int             TOC   = 8;
  localparam logic [24:0]    WBASE = 25'h1FFFFFE;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req, cpu_we, mem_cmd_ready, mem_rsp_valid;
  logic [12:0] cpu_addr;
  logic [15:0] cpu_wdata, mem_rsp_data;
  logic        cpu_busy, cpu_ack, cpu_err, mem_cmd_valid, mem_cmd_we, dbg_stale;
  logic [15:0] cpu_rdata, mem_cmd_wdata;
  logic [24:0] mem_cmd_addr;
  state_t      dbg_state;
  logic        w_busy, w_ack, w_err, w_valid, w_we, w_stale;
  logic [15:0] w_rdata, w_wdata;
  logic [24:0] w_addr;
  state_t      w_state;

  int total = 0;
  int bad   = 0;
  int n;
  logic [15:0] exp_q[$];
  logic [15:0] exp_rd;

  typedef struct {
    logic        req, we;
    logic [12:0] addr;
    logic [15:0] wdata;
    logic        rdy, rv;
    logic [15:0] rdat;
    logic        e_busy, e_ack, e_err, e_valid, e_we;
    logic [24:0] e_addr;
    logic [15:0] e_wdata, e_rdata;
  } vec_t;
  vec_t vq[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, want finish before 200000");
    $fatal(1, "watchdog");
  end

  mem_bridge #(.BASE(25'h0), .TO_CYC(TOC)) u_dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata), .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .dbg_state(dbg_state), .dbg_stale(dbg_stale)
  );

  mem_bridge #(.BASE(WBASE), .TO_CYC(TOC)) u_wrap (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_busy(w_busy), .cpu_ack(w_ack), .cpu_err(w_err),
    .cpu_rdata(w_rdata), .mem_cmd_valid(w_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(w_we), .mem_cmd_addr(w_addr), .mem_cmd_wdata(w_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .dbg_state(w_state), .dbg_stale(w_stale)
  );

  // A response with nothing outstanding and nothing stale is a memory-side protocol error.
  always @(negedge clk) begin
    if (rst && mem_rsp_valid && !dbg_stale && dbg_state != RSP) begin
      bad++;
      $display("FAIL stray_rsp: rsp_valid seen in state %0d with stale=0", dbg_state);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic req, input logic we, input logic [12:0] a,
                        input logic [15:0] wd, input logic rdy, input logic rv,
                        input logic [15:0] rd);
    cpu_req       = req;
    cpu_we        = we;
    cpu_addr      = a;
    cpu_wdata     = wd;
    mem_cmd_ready = rdy;
    mem_rsp_valid = rv;
    mem_rsp_data  = rd;
  endtask

  task automatic add(input logic req, input logic we, input logic [12:0] a,
                     input logic [15:0] wd, input logic rdy, input logic rv,
                     input logic [15:0] rd, input logic eb, input logic ea,
                     input logic ee, input logic ev, input logic ew,
                     input logic [24:0] ead, input logic [15:0] ewd, input logic [15:0] erd);
    vec_t v;
    v.req = req; v.we = we; v.addr = a; v.wdata = wd; v.rdy = rdy; v.rv = rv; v.rdat = rd;
    v.e_busy = eb; v.e_ack = ea; v.e_err = ee; v.e_valid = ev; v.e_we = ew;
    v.e_addr = ead; v.e_wdata = ewd; v.e_rdata = erd;
    vq.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic eb, input logic ea, input logic ee,
                         input logic ev, input logic ew, input logic [24:0] ead,
                         input logic [15:0] ewd, input logic [15:0] erd);
    chk({nm, ".busy"},  32'(cpu_busy),      32'(eb));
    chk({nm, ".ack"},   32'(cpu_ack),       32'(ea));
    chk({nm, ".err"},   32'(cpu_err),       32'(ee));
    chk({nm, ".valid"}, 32'(mem_cmd_valid), 32'(ev));
    chk({nm, ".we"},    32'(mem_cmd_we),    32'(ew));
    chk({nm, ".addr"},  32'(mem_cmd_addr),  32'(ead));
    chk({nm, ".wdata"}, 32'(mem_cmd_wdata), 32'(ewd));
    chk({nm, ".rdata"}, 32'(cpu_rdata),     32'(erd));
  endtask

  task automatic wait_ack(input string nm, output int cyc);
    cyc = 0;
    while (!cpu_ack && cyc < 40) begin
      tick();
      cyc++;
    end
    if (!cpu_ack) chk({nm, ".ack_timeout"}, 32'(cpu_ack), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_in(1'b0, 1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 25'h0, 16'h0, 16'h0);
    chk("reset.state", 32'(dbg_state), 32'(IDLE));
    chk("reset.stale", 32'(dbg_stale), 0);
    chk("reset.wrap_outs", 32'({w_busy, w_ack, w_err, w_valid, w_we, w_stale}), 0);
    chk("reset.wrap_data", 32'({w_rdata, w_wdata}), 0);
    chk("reset.wrap_state", 32'(w_state), 32'(IDLE));
    rst = 1'b1;
    tick();

    // inputs apply during cycle i; expected outputs are those of cycle i+1
    //   req   we    addr      wdata     rdy   rv    rdat      busy  ack   err   valid we    addr       wdata     rdata
    add(1'b1, 1'b1, 13'h0005, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 25'h000005, 16'h1234, 16'h0000);
    add(1'b0, 1'b0, 13'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 25'h000005, 16'h1234, 16'h0000);
    add(1'b0, 1'b0, 13'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 25'h000005, 16'h1234, 16'h0000);
    add(1'b1, 1'b0, 13'h0010, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 25'h000010, 16'h0000, 16'h0000);
    add(1'b0, 1'b0, 13'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 25'h000010, 16'h0000, 16'h0000);
    add(1'b0, 1'b0, 13'h0000, 16'h0000, 1'b0, 1'b1, 16'hA5A5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 25'h000010, 16'h0000, 16'hA5A5);
    add(1'b0, 1'b0, 13'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 25'h000010, 16'h0000, 16'hA5A5);
    add(1'b1, 1'b1, 13'h0003, 16'h0777, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 25'h000003, 16'h0777, 16'hA5A5);
    add(1'b1, 1'b0, 13'h001F, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 25'h000003, 16'h0777, 16'hA5A5);
    add(1'b0, 1'b0, 13'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 25'h000003, 16'h0777, 16'hA5A5);
    add(1'b1, 1'b0, 13'h0008, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 25'h000003, 16'h0777, 16'hA5A5);
    add(1'b1, 1'b0, 13'h0009, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 25'h000009, 16'h0000, 16'hA5A5);
    add(1'b0, 1'b0, 13'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 25'h000009, 16'h0000, 16'hA5A5);
    add(1'b0, 1'b0, 13'h0000, 16'h0000, 1'b0, 1'b1, 16'h1357, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 25'h000009, 16'h0000, 16'h1357);
    add(1'b0, 1'b0, 13'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 25'h000009, 16'h0000, 16'h1357);

    foreach (vq[i]) begin
      set_in(vq[i].req, vq[i].we, vq[i].addr, vq[i].wdata, vq[i].rdy, vq[i].rv, vq[i].rdat);
      tick();
      chk_all($sformatf("vec%0d", i), vq[i].e_busy, vq[i].e_ack, vq[i].e_err, vq[i].e_valid,
              vq[i].e_we, vq[i].e_addr, vq[i].e_wdata, vq[i].e_rdata);
      chk($sformatf("vec%0d.wrap_addr", i), 32'(w_addr), 32'(25'(vq[i].e_addr + WBASE)));
      chk($sformatf("vec%0d.wrap_hs", i), 32'({w_busy, w_ack, w_valid}),
          32'({vq[i].e_busy, vq[i].e_ack, vq[i].e_valid}));
      if (i == 7) chk("wrap_addr3", 32'(w_addr), 32'(25'h0000001));
    end

    // read with ready after 3 wait cycles, response 2 cycles after accept
    set_in(1'b1, 1'b0, 13'h0ABC, 16'h0, 1'b0, 1'b0, 16'h0);
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("dly.c%0d.valid", c), 32'(mem_cmd_valid), 1);
      chk($sformatf("dly.c%0d.addr", c), 32'(mem_cmd_addr), 32'(25'h0ABC));
      chk($sformatf("dly.c%0d.busy", c), 32'(cpu_busy), 1);
      set_in(1'b0, 1'b0, 13'h0, 16'h0, (c == 4), 1'b0, 16'h0);
      tick();
    end
    chk("dly.rsp1", 32'({cpu_busy, mem_cmd_valid, cpu_ack}), 32'(3'b100));
    set_in(1'b0, 1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    tick();
    chk("dly.rsp2", 32'({cpu_busy, mem_cmd_valid, cpu_ack}), 32'(3'b100));
    set_in(1'b0, 1'b0, 13'h0, 16'h0, 1'b0, 1'b1, 16'hBEEF);
    exp_q.push_back(16'hBEEF);
    tick();
    exp_rd = exp_q.pop_front();
    chk("dly.ack", 32'({cpu_busy, cpu_ack, cpu_err}), 32'(3'b110));
    chk("dly.rdata", 32'(cpu_rdata), 32'(exp_rd));
    set_in(1'b0, 1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    tick();
    chk("dly.idle", 32'({cpu_busy, cpu_ack}), 0);
    chk("dly.hold", 32'(cpu_rdata), 32'(16'hBEEF));

    // read accepted, no response: times out after TO_CYC cycles in CMD+RSP
    set_in(1'b1, 1'b0, 13'h0100, 16'h0, 1'b1, 1'b0, 16'h0);
    tick();
    set_in(1'b0, 1'b0, 13'h0, 16'h0, 1'b1, 1'b0, 16'h0);
    tick();
    chk("to.state", 32'(dbg_state), 32'(RSP));
    set_in(1'b0, 1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    wait_ack("to", n);
    chk("to.latency", 32'(n + 1), TOC);
    chk("to.err", 32'(cpu_err), 1);
    chk("to.rdata", 32'(cpu_rdata), 32'(16'hDEAD));
    chk("to.stale", 32'(dbg_stale), 1);
    tick();
    chk("to.idle_stale", 32'({cpu_busy, dbg_stale}), 32'(2'b01));
    set_in(1'b1, 1'b0, 13'h0200, 16'h0, 1'b1, 1'b0, 16'h0);
    tick();
    chk("stale.drop_busy", 32'(cpu_busy), 0);
    chk("stale.drop_valid", 32'(mem_cmd_valid), 0);
    set_in(1'b0, 1'b0, 13'h0, 16'h0, 1'b0, 1'b1, 16'h5555);
    tick();
    chk("stale.cleared", 32'(dbg_stale), 0);
    chk("stale.rdata", 32'(cpu_rdata), 32'(16'hDEAD));
    chk("stale.no_ack", 32'({cpu_ack, cpu_busy}), 0);
    set_in(1'b0, 1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    tick();

    // second timed-out read: stale forgets itself after TO_CYC cycles
    set_in(1'b1, 1'b0, 13'h0101, 16'h0, 1'b1, 1'b0, 16'h0);
    tick();
    tick();
    set_in(1'b0, 1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    wait_ack("to2", n);
    chk("to2.err", 32'(cpu_err), 1);
    n = 0;
    while (dbg_stale && n < 40) begin
      n++;
      tick();
    end
    chk("stale.life", 32'(n), TOC);

    // reset while a read waits in RSP
    set_in(1'b1, 1'b0, 13'h0033, 16'h0, 1'b1, 1'b0, 16'h0);
    tick();
    set_in(1'b0, 1'b0, 13'h0, 16'h0, 1'b1, 1'b0, 16'h0);
    tick();
    chk("rst.pre_state", 32'(dbg_state), 32'(RSP));
    set_in(1'b0, 1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    #2 rst = 1'b0;
    #1;
    chk_all("rst.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 25'h0, 16'h0, 16'h0);
    chk("rst.state", 32'(dbg_state), 32'(IDLE));
    tick();
    rst = 1'b1;
    tick();
    chk("rst.after_state", 32'(dbg_state), 32'(IDLE));
    chk("rst.after_stale", 32'(dbg_stale), 0);
    set_in(1'b1, 1'b0, 13'h0044, 16'h0, 1'b1, 1'b0, 16'h0);
    tick();
    chk("rst.rd_valid", 32'(mem_cmd_valid), 1);
    set_in(1'b0, 1'b0, 13'h0, 16'h0, 1'b1, 1'b0, 16'h0);
    tick();
    set_in(1'b0, 1'b0, 13'h0, 16'h0, 1'b0, 1'b1, 16'h4321);
    exp_q.push_back(16'h4321);
    tick();
    exp_rd = exp_q.pop_front();
    chk("rst.rd_ack", 32'({cpu_ack, cpu_err}), 32'(2'b10));
    chk("rst.rd_data", 32'(cpu_rdata), 32'(exp_rd));
    set_in(1'b0, 1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    tick();

    // write never accepted: times out in CMD, rdata untouched, no stale
    set_in(1'b1, 1'b1, 13'h0042, 16'h9999, 1'b0, 1'b0, 16'h0);
    tick();
    set_in(1'b0, 1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("wto.valid", 32'(mem_cmd_valid), 1);
    wait_ack("wto", n);
    chk("wto.latency", 32'(n + 1), TOC + 1);
    chk("wto.err", 32'(cpu_err), 1);
    chk("wto.valid_drop", 32'(mem_cmd_valid), 0);
    chk("wto.rdata", 32'(cpu_rdata), 32'(16'h4321));
    chk("wto.stale", 32'(dbg_stale), 0);
    tick();
    chk("wto.idle", 32'({cpu_busy, cpu_ack, cpu_err}), 0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Sits directly downstream of the RISC_V core's memory port (memAddr/writeData/writeEn/readData) and upstream of the SDRAM controller command interface.
- Converts single CPU load/store requests into a valid/ready command plus response handshake.
- Stalls the core via a busy flag and returns read data with a one-cycle acknowledge.
- Provides a response timeout so a dead memory side cannot hang the core forever.

Parameters:
- bW, 16, data width in bits (matches core).
- aW, 13, CPU address width in bits (matches core memAddr).
- MAW, 25, memory-side address width in bits.
- BASE, 0, MAW-bit offset added to every CPU address.
- TO_CYC, 255, timeout limit in cycles spent in CMD+RSP (must be >= 2).
- ERR_DATA, 16'hDEAD, value returned on cpu_rdata when a read times out.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- cpu_req  in  1  one-cycle request pulse; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load; sampled with cpu_req.
- cpu_addr  in  aW  word address; sampled with cpu_req.
- cpu_wdata  in  bW  store data; sampled with cpu_req.
- cpu_busy  out  1  high in every state except IDLE.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_ack; 1 = timeout.
- cpu_rdata  out  bW  load data; held from ack until the next ack.
- mem_cmd_valid  out  1  command valid.
- mem_cmd_ready  in  1  controller accepts the command.
- mem_cmd_we  out  1  command is a write.
- mem_cmd_addr  out  MAW  BASE + zero-extended cpu_addr, wrapping modulo 2^MAW.
- mem_cmd_wdata  out  bW  write data.
- mem_rsp_valid  in  1  read response valid for one cycle.
- mem_rsp_data  in  bW  read response data.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; stale=0; timeout counter=0.
- All outputs 0 during reset, cpu_rdata included.
- All outputs are driven from registers; there is no combinational path from any input to any output.
- States: IDLE, CMD, RSP, ACK.
- IDLE:
  - cpu_req=1 and stale=0: latch we/addr/wdata, clear the counter, go to CMD.
  - cpu_req=1 and stale=1: the request is dropped; cpu_busy stays 0 and no ack is issued. The core must not issue requests while stale is set; the core guarantees this by design.
- CMD:
  - mem_cmd_valid=1; we/addr/wdata held stable until the handshake (valid & ready in the same cycle).
  - Handshake with write: go to ACK (posted write).
  - Handshake with read: go to RSP.
- RSP:
  - mem_rsp_valid=1: capture mem_rsp_data into cpu_rdata, go to ACK with err=0.
- ACK: cpu_ack=1 for exactly one cycle, then IDLE.
- Latencies:
  - Write: req in cycle N, valid in N+1; ready in cycle M gives ack in M+1.
  - Zero-wait read (ready in N+1, response in N+2): ack in N+3.
- cpu_busy=1 from the cycle after req through the ack cycle.
- Timeout counter:
  - Increments every cycle in CMD or RSP, saturating.
  - When it reaches TO_CYC-1 with no completion that cycle, go to ACK with cpu_err=1.
  - If that happens in CMD, mem_cmd_valid drops; the controller tolerates command withdrawal.
  - If the timed-out access is a read, cpu_rdata=ERR_DATA.
  - If it happens in RSP, also set stale=1.
  - A completion in the same cycle as the timeout limit wins: err=0.
- stale flag:
  - While stale=1, the next mem_rsp_valid is discarded and clears stale.
  - stale also self-clears after a further TO_CYC cycles (the counter is reused while in IDLE).
- mem_rsp_valid outside RSP with stale=0 is ignored. It is flagged by the bench assertion only.
- cpu_req arriving outside IDLE is ignored; no queueing.
- Reset asserted mid-access: immediate return to IDLE, with any in-flight command abandoned.

Decomposition:
- Shared package mem_bridge_pkg holds:
  - the state enum (IDLE, CMD, RSP, ACK), encoded 2 bits;
  - localparam CNT_W = $clog2(TO_CYC+1).
- One sub-module, to_counter: a saturating up-counter with clear and enable that outputs a hit flag at TO_CYC-1. It is reused for both the access timeout and the stale timeout.

Test Plan:
- Write, ready tied high, addr=13'h0005, wdata=16'h1234, BASE=0: mem_cmd_addr=25'h5 and valid for 1 cycle; ack 2 cycles after req; err=0.
- Read, ready delayed 3 cycles, rsp_data=16'hBEEF 2 cycles after accept: valid held stable for 4 cycles; cpu_rdata=16'hBEEF at ack; busy high throughout.
- Read, no response, TO_CYC=8: ack with err=1 and rdata=16'hDEAD; stale=1. A later rsp_valid with 16'h5555 is discarded, rdata is unchanged and stale clears.
- BASE=25'h1FFFFFE, addr=13'h0003: mem_cmd_addr=25'h0000001 (wrap).
- Back-to-back: req pulsed during busy is ignored (no second command). Req the cycle after ack is accepted.
- Reset asserted while in RSP: all outputs 0 asynchronously; after release state=IDLE, stale=0, and the next read completes normally.
